// File: rtl/operand_serializer.sv
// Operand serializer: accepts a parallel (A, B) operand pair per handshake and
// streams it LSB first, one bit pair per beat, with a one-word pending buffer
// so back-to-back words stream without bubble beats.
module operand_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_vld,
    output logic             o_rdy,
    output logic             o_A,
    output logic             o_B,
    output logic             o_vld,
    output logic             o_last,
    input  logic             i_rdy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic [WIDTH-1:0] r_pend_a;
    logic [WIDTH-1:0] r_pend_b;
    logic             r_pend_vld;

    logic w_last;
    logic w_in_fire;
    logic w_out_fire;
    logic w_last_fire;

    // Output view of the shift state; o_rdy only reflects reset and the pending slot
    assign w_last      = r_active && (r_cnt == LAST_CNT);
    assign o_vld       = r_active;
    assign o_A         = r_sh_a[0];
    assign o_B         = r_sh_b[0];
    assign o_last      = w_last;
    assign o_rdy       = i_reset_n && !r_pend_vld;

    assign w_in_fire   = i_vld && o_rdy;
    assign w_out_fire  = r_active && i_rdy;
    assign w_last_fire = w_out_fire && w_last;

    // Shift register, bit counter and active flag; a finishing word hands over
    // to the pending word first, then to a fresh input word, else goes idle
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (!r_active) begin
            if (w_in_fire) begin
                r_sh_a   <= i_A;
                r_sh_b   <= i_B;
                r_cnt    <= '0;
                r_active <= 1'b1;
            end
        end else if (w_last_fire) begin
            if (r_pend_vld) begin
                r_sh_a <= r_pend_a;
                r_sh_b <= r_pend_b;
                r_cnt  <= '0;
            end else if (w_in_fire) begin
                r_sh_a <= i_A;
                r_sh_b <= i_B;
                r_cnt  <= '0;
            end else begin
                r_active <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_sh_a <= r_sh_a >> 1;
            r_sh_b <= r_sh_b >> 1;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Pending slot: filled while a word is mid-flight, drained when it finishes
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pend_a   <= '0;
            r_pend_b   <= '0;
            r_pend_vld <= 1'b0;
        end else if (r_active && w_last_fire) begin
            r_pend_vld <= 1'b0;
        end else if (r_active && w_in_fire) begin
            r_pend_a   <= i_A;
            r_pend_b   <= i_B;
            r_pend_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
// Self-checking bench for operand_serializer at WIDTH=8 and WIDTH=1 against a
// bit-stream queue model.
module tb_operand_serializer;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic         rst_n, vld, drdy;
    logic [W-1:0] a, b;
    logic         rdy, oa, ob, ovld, olast;

    operand_serializer #(.WIDTH(W)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_A(a), .i_B(b), .i_vld(vld),
        .o_rdy(rdy), .o_A(oa), .o_B(ob), .o_vld(ovld), .o_last(olast), .i_rdy(drdy)
    );

    // WIDTH=1 instance
    logic       rst1_n, vld1, drdy1;
    logic [0:0] a1, b1;
    logic       rdy1, oa1, ob1, ovld1, olast1;

    operand_serializer #(.WIDTH(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst1_n), .i_A(a1), .i_B(b1), .i_vld(vld1),
        .o_rdy(rdy1), .o_A(oa1), .o_B(ob1), .o_vld(ovld1), .o_last(olast1), .i_rdy(drdy1)
    );

    int total = 0;
    int bad   = 0;

    // Model: queue of beats still owed downstream, each {last, a_bit, b_bit}
    logic [2:0] q8[$];
    logic [2:0] q1[$];

    // Per-cycle expected/observed vectors: {vld, last, a, b, rdy}
    logic [4:0] e8, o8, e1, o1;
    logic       f_in, f_out;

    function automatic logic [4:0] exp_vec(input logic r, input int qsize, input logic [2:0] head,
                                           input int unsigned width);
        int unsigned words;
        words = (qsize + width - 1) / width;
        if (qsize == 0) return {4'b0000, r};
        return {1'b1, head, r && (words < 2)};
    endfunction

    task automatic cyc8(input logic r, input logic v, input logic dr,
                        input logic [W-1:0] wa, input logic [W-1:0] wb);
        @(negedge clk);
        rst_n = r; vld = v; drdy = dr; a = wa; b = wb;
        #1;
        e8 = exp_vec(r, q8.size(), (q8.size() > 0) ? q8[0] : 3'b000, W);
        o8 = ovld ? {1'b1, olast, oa, ob, rdy} : {1'b0, olast, 2'b00, rdy};
        f_in  = v && e8[0];
        f_out = e8[4] && dr;
        if (!r) q8.delete();
        else begin
            if (f_out) void'(q8.pop_front());
            if (f_in) for (int i = 0; i < int'(W); i++) q8.push_back({(i == int'(W) - 1), wa[i], wb[i]});
        end
    endtask

    task automatic cyc1(input logic r, input logic v, input logic dr, input logic wa, input logic wb);
        @(negedge clk);
        rst1_n = r; vld1 = v; drdy1 = dr; a1 = wa; b1 = wb;
        #1;
        e1 = exp_vec(r, q1.size(), (q1.size() > 0) ? q1[0] : 3'b000, 1);
        o1 = ovld1 ? {1'b1, olast1, oa1, ob1, rdy1} : {1'b0, olast1, 2'b00, rdy1};
        f_in  = v && e1[0];
        f_out = e1[4] && dr;
        if (!r) q1.delete();
        else begin
            if (f_out) void'(q1.pop_front());
            if (f_in) q1.push_back({1'b1, wa, wb});
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc8(1'b0, 1'b1, 1'b1, W'($urandom), W'($urandom));
            total++;
            if (o8 !== 5'b00000 || {oa, ob} !== 2'b00) begin
                bad++; $display("FAIL reset got=%b ab=%b want=00000 ab=00", o8, {oa, ob});
            end
        end
        cyc8(1'b1, 1'b0, 1'b1, '0, '0);
        total++;
        if (o8 !== 5'b00001) begin bad++; $display("FAIL reset_release got=%b want=00001", o8); end
    endtask

    task automatic test_single();
        logic [W-1:0] ga, gb;
        int n, lastpos;
        n = 0; lastpos = -1; ga = '0; gb = '0;
        cyc8(1'b1, 1'b1, 1'b1, 8'h5A, 8'hC3);
        for (int c = 0; c < 11; c++) begin
            cyc8(1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom));
            total++;
            if (o8 !== e8) begin bad++; $display("FAIL single cyc%0d got=%b want=%b", c, o8, e8); end
            if (ovld && n < int'(W)) begin
                ga[n] = oa; gb[n] = ob;
                if (olast) lastpos = n;
                n++;
            end
        end
        total++;
        if (ga !== 8'h5A || gb !== 8'hC3 || lastpos != 7 || n != 8) begin
            bad++; $display("FAIL single_word got a=%h b=%h last=%0d n=%0d want a=5a b=c3 last=7 n=8",
                            ga, gb, lastpos, n);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] wa[3], wb[3];
        int idx, beats, lasts_ok, started, gap;
        idx = 0; beats = 0; lasts_ok = 0; started = 0; gap = 0;
        for (int i = 0; i < 3; i++) begin wa[i] = W'($urandom); wb[i] = W'($urandom); end
        for (int c = 0; c < 40; c++) begin
            cyc8(1'b1, idx < 3, 1'b1, (idx < 3) ? wa[idx] : '0, (idx < 3) ? wb[idx] : '0);
            if (f_in) idx++;
            total++;
            if (o8 !== e8) begin bad++; $display("FAIL b2b cyc%0d got=%b want=%b", c, o8, e8); end
            if (ovld) begin
                if (started == 2) gap = 1;
                started = 1; beats++;
                if (olast && (beats % 8 == 0)) lasts_ok++;
            end else if (started == 1) started = 2;
        end
        total++;
        if (beats != 24 || lasts_ok != 3 || gap != 0) begin
            bad++; $display("FAIL b2b_stream got beats=%0d lasts=%0d gap=%0d want 24/3/0", beats, lasts_ok, gap);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] ga;
        int fired;
        fired = 0; ga = '0;
        cyc8(1'b1, 1'b1, 1'b1, 8'hB6, 8'h29);
        for (int c = 0; c < 20; c++) begin
            cyc8(1'b1, 1'b0, !(fired == 3 && c < 8) ? 1'b1 : 1'b0, '0, '0);
            total++;
            if (o8 !== e8) begin bad++; $display("FAIL stall cyc%0d got=%b want=%b", c, o8, e8); end
            if (ovld && drdy && fired < int'(W)) begin ga[fired] = oa; fired++; end
        end
        total++;
        if (fired != 8 || ga !== 8'hB6) begin
            bad++; $display("FAIL stall_total got fired=%0d a=%h want 8 b6", fired, ga);
        end
    endtask

    task automatic test_reset_mid();
        cyc8(1'b1, 1'b1, 1'b1, 8'hAA, 8'h55);
        cyc8(1'b1, 1'b1, 1'b1, 8'h0F, 8'hF0);
        for (int c = 0; c < 3; c++) cyc8(1'b1, 1'b0, 1'b1, '0, '0);
        cyc8(1'b0, 1'b1, 1'b1, '0, '0);
        total++;
        if (o8 !== e8 || o8[4] !== 1'b1) begin bad++; $display("FAIL rmid_bit4 got=%b want=%b", o8, e8); end
        cyc8(1'b0, 1'b0, 1'b1, '0, '0);
        total++;
        if (o8 !== 5'b00000) begin bad++; $display("FAIL rmid_cleared got=%b want=00000", o8); end
        cyc8(1'b1, 1'b1, 1'b1, 8'h01, 8'h00);
        total++;
        if (o8 !== 5'b00001) begin bad++; $display("FAIL rmid_release got=%b want=00001", o8); end
        cyc8(1'b1, 1'b0, 1'b1, '0, '0);
        total++;
        if (o8 !== e8 || !ovld || oa !== 1'b1) begin
            bad++; $display("FAIL rmid_newword got=%b oa=%b want=%b oa=1", o8, oa, e8);
        end
        for (int c = 0; c < 9; c++) cyc8(1'b1, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic test_adder();
        logic [W-1:0] pa[2], pb[2];
        pa[0] = 8'hFF; pb[0] = 8'h01; pa[1] = 8'h12; pb[1] = 8'h34;
        for (int p = 0; p < 2; p++) begin
            logic [W:0] want;
            logic [W-1:0] sum;
            logic c_in, ovf;
            int n;
            want = (W+1)'(pa[p]) + (W+1)'(pb[p]);
            sum = '0; c_in = 1'b0; ovf = 1'b0; n = 0;
            cyc8(1'b1, 1'b1, 1'b1, pa[p], pb[p]);
            for (int c = 0; c < 10; c++) begin
                cyc8(1'b1, 1'b0, 1'b1, '0, '0);
                if (ovld && n < int'(W)) begin
                    sum[n] = oa ^ ob ^ c_in;
                    c_in   = (oa & ob) | (c_in & (oa ^ ob));
                    if (olast) ovf = c_in;
                    n++;
                end
            end
            total++;
            if (sum !== want[W-1:0] || ovf !== want[W]) begin
                bad++; $display("FAIL adder%0d got sum=%h ovf=%b want sum=%h ovf=%b", p, sum, ovf, want[W-1:0], want[W]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc8(1'b1, 1'($urandom), ($urandom % 4) != 0, W'($urandom), W'($urandom));
            total++;
            if (o8 !== e8) begin bad++; $display("FAIL random cyc%0d got=%b want=%b", c, o8, e8); end
        end
        for (int c = 0; c < 20; c++) cyc8(1'b1, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic test_width1();
        int beats, lasts;
        beats = 0; lasts = 0;
        cyc1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (o1 !== e1 || o1 !== 5'b11101) begin bad++; $display("FAIL w1_beat0 got=%b want=11101", o1); end
        if (ovld1) begin beats++; if (olast1) lasts++; end
        cyc1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (o1 !== e1 || o1 !== 5'b11011) begin bad++; $display("FAIL w1_beat1 got=%b want=11011", o1); end
        if (ovld1) begin beats++; if (olast1) lasts++; end
        cyc1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (o1 !== 5'b00001 || beats != 2 || lasts != 2) begin
            bad++; $display("FAIL w1_done got=%b beats=%0d lasts=%0d want 00001 2 2", o1, beats, lasts);
        end
        for (int c = 0; c < 100; c++) begin
            cyc1(1'b1, 1'($urandom), ($urandom % 3) != 0, 1'($urandom), 1'($urandom));
            total++;
            if (o1 !== e1) begin bad++; $display("FAIL w1_random cyc%0d got=%b want=%b", c, o1, e1); end
        end
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; drdy = 1'b0; a = '0; b = '0;
        rst1_n = 1'b0; vld1 = 1'b0; drdy1 = 1'b0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_adder();
        test_random();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
